// File: rtl/mem_fill_verify_ctrl.sv
// Fill / verify sequencer and user-port arbiter for one simple dual-port BRAM.
// Sweeps every address writing a seeded pattern, reading it back and counting
// mismatches; while idle the user port gets direct access to the memory.
`timescale 1ns/1ps
module mem_fill_verify_ctrl #(
    parameter int WID_MEM   = 4,
    parameter int DEPTH_MEM = 4096,
    parameter int ERR_W     = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [WID_MEM-1:0] seed,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic [ERR_W-1:0]   err_cnt,
    output logic [31:0]        first_err_addr,
    input  logic               usr_we,
    input  logic [31:0]        usr_waddr,
    input  logic [WID_MEM-1:0] usr_wdata,
    input  logic               usr_re,
    input  logic [31:0]        usr_raddr,
    output logic               usr_gnt,
    output logic [WID_MEM-1:0] usr_rdata,
    output logic               usr_rvalid,
    output logic               mem_we,
    output logic [31:0]        mem_waddr,
    output logic [WID_MEM-1:0] mem_din,
    output logic [31:0]        mem_raddr,
    input  logic [WID_MEM-1:0] mem_dout
);

    localparam int AW = (DEPTH_MEM > 1) ? $clog2(DEPTH_MEM) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH_MEM - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FILL   = 3'd1,
        S_VERIFY = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    // Pattern for an address: low address bits (zero-extended) xor seed.
    function automatic logic [WID_MEM-1:0] pattern_f(input logic [AW-1:0] a,
                                                     input logic [WID_MEM-1:0] s);
        logic [AW+WID_MEM-1:0] ext_v;
        ext_v = {{WID_MEM{1'b0}}, a};
        return ext_v[WID_MEM-1:0] ^ s;
    endfunction

    // Sweep address widened to the 32-bit memory address bus.
    function automatic logic [31:0] addr32_f(input logic [AW-1:0] a);
        return {{(32 - AW){1'b0}}, a};
    endfunction

    state_e             state_q, state_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [WID_MEM-1:0] seed_q, seed_d;
    logic [1:0]         mode_q, mode_d;
    logic               cmp_valid_q, cmp_valid_d;
    logic [AW-1:0]      cmp_addr_q, cmp_addr_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
    logic [31:0]        first_err_q, first_err_d;
    logic               aborted_q, aborted_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               usr_rvalid_q, usr_rvalid_d;
    logic [31:0]        waddr_hold_q, waddr_hold_d;
    logic [31:0]        raddr_hold_q, raddr_hold_d;

    logic               usr_gnt_s;
    logic               compare_s;
    logic               mem_we_s;
    logic [31:0]        mem_waddr_s;
    logic [WID_MEM-1:0] mem_din_s;
    logic [31:0]        mem_raddr_s;

    // Next-state, memory port mux and compare logic.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        seed_d       = seed_q;
        mode_d       = mode_q;
        cmp_valid_d  = 1'b0;
        cmp_addr_d   = cmp_addr_q;
        err_cnt_d    = err_cnt_q;
        first_err_d  = first_err_q;
        aborted_d    = aborted_q;
        usr_rvalid_d = 1'b0;
        compare_s    = 1'b0;
        mem_we_s     = 1'b0;
        mem_waddr_s  = waddr_hold_q;
        mem_din_s    = {WID_MEM{1'b0}};
        mem_raddr_s  = raddr_hold_q;
        usr_gnt_s    = (state_q == S_IDLE) && reset_n;

        case (state_q)
            S_IDLE: begin
                if (usr_gnt_s && usr_we) begin
                    mem_we_s    = 1'b1;
                    mem_waddr_s = usr_waddr;
                    mem_din_s   = usr_wdata;
                end else begin
                    mem_we_s    = 1'b0;
                end
                if (usr_gnt_s && usr_re) begin
                    mem_raddr_s  = usr_raddr;
                    usr_rvalid_d = 1'b1;
                end else begin
                    usr_rvalid_d = 1'b0;
                end
                if (start && (mode != 2'b00)) begin
                    state_d     = (mode == 2'b10) ? S_VERIFY : S_FILL;
                    err_cnt_d   = {ERR_W{1'b0}};
                    first_err_d = 32'd0;
                    aborted_d   = 1'b0;
                    seed_d      = seed;
                    mode_d      = mode;
                    addr_d      = {AW{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FILL: begin
                mem_we_s    = 1'b1;
                mem_waddr_s = addr32_f(addr_q);
                mem_din_s   = pattern_f(addr_q, seed_q);
                if (abort) begin
                    state_d   = S_DONE;
                    aborted_d = 1'b1;
                end else if (addr_q == LAST_ADDR) begin
                    addr_d  = {AW{1'b0}};
                    state_d = (mode_q == 2'b11) ? S_VERIFY : S_DONE;
                end else begin
                    addr_d = addr_q + AW'(1);
                end
            end
            S_VERIFY: begin
                mem_raddr_s = addr32_f(addr_q);
                if (abort) begin
                    // The read issued now and the one in flight are both dropped.
                    state_d   = S_DONE;
                    aborted_d = 1'b1;
                end else begin
                    compare_s   = cmp_valid_q;
                    cmp_valid_d = 1'b1;
                    cmp_addr_d  = addr_q;
                    if (addr_q == LAST_ADDR) begin
                        state_d = S_DRAIN;
                    end else begin
                        addr_d = addr_q + AW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    state_d   = S_DONE;
                    aborted_d = 1'b1;
                end else begin
                    compare_s = cmp_valid_q;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (compare_s && (mem_dout != pattern_f(cmp_addr_q, seed_q))) begin
            if (err_cnt_q == {ERR_W{1'b0}}) begin
                first_err_d = addr32_f(cmp_addr_q);
            end else begin
                first_err_d = first_err_q;
            end
            if (err_cnt_q != {ERR_W{1'b1}}) begin
                err_cnt_d = err_cnt_q + ERR_W'(1);
            end else begin
                err_cnt_d = err_cnt_q;
            end
        end else begin
            compare_s = compare_s;
        end

        waddr_hold_d = mem_waddr_s;
        raddr_hold_d = mem_raddr_s;
        busy_d       = (state_d == S_FILL) || (state_d == S_VERIFY) || (state_d == S_DRAIN);
        done_d       = (state_d == S_DONE);
    end

    // State and datapath registers; async active-low reset clears everything.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            addr_q       <= {AW{1'b0}};
            seed_q       <= {WID_MEM{1'b0}};
            mode_q       <= 2'b00;
            cmp_valid_q  <= 1'b0;
            cmp_addr_q   <= {AW{1'b0}};
            err_cnt_q    <= {ERR_W{1'b0}};
            first_err_q  <= 32'd0;
            aborted_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            usr_rvalid_q <= 1'b0;
            waddr_hold_q <= 32'd0;
            raddr_hold_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            seed_q       <= seed_d;
            mode_q       <= mode_d;
            cmp_valid_q  <= cmp_valid_d;
            cmp_addr_q   <= cmp_addr_d;
            err_cnt_q    <= err_cnt_d;
            first_err_q  <= first_err_d;
            aborted_q    <= aborted_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            usr_rvalid_q <= usr_rvalid_d;
            waddr_hold_q <= waddr_hold_d;
            raddr_hold_q <= raddr_hold_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign aborted        = aborted_q;
    assign err_cnt        = err_cnt_q;
    assign first_err_addr = first_err_q;
    assign usr_gnt        = usr_gnt_s;
    assign usr_rvalid     = usr_rvalid_q;
    assign usr_rdata      = usr_rvalid_q ? mem_dout : {WID_MEM{1'b0}};
    assign mem_we         = mem_we_s;
    assign mem_waddr      = mem_waddr_s;
    assign mem_din        = mem_din_s;
    assign mem_raddr      = mem_raddr_s;

endmodule

// File: tb/tb_mem_fill_verify_ctrl.sv
// Bench for mem_fill_verify_ctrl: BRAM model plus a reference image of the
// memory contents from which sweep timing and verify results are predicted.
`timescale 1ns/1ps
module tb_mem_fill_verify_ctrl;
    localparam int D  = 4096;
    localparam int W  = 4;
    localparam int EW = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [1:0]    mode;
    logic [W-1:0]  seed;
    logic          abort;
    logic          busy, done, aborted;
    logic [EW-1:0] err_cnt;
    logic [31:0]   first_err_addr;
    logic          usr_we;
    logic [31:0]   usr_waddr;
    logic [W-1:0]  usr_wdata;
    logic          usr_re;
    logic [31:0]   usr_raddr;
    logic          usr_gnt;
    logic [W-1:0]  usr_rdata;
    logic          usr_rvalid;
    logic          mem_we;
    logic [31:0]   mem_waddr;
    logic [W-1:0]  mem_din;
    logic [31:0]   mem_raddr;
    logic [W-1:0]  mem_dout;

    logic [W-1:0]  mem_arr [0:D-1];
    logic [W-1:0]  ref_mem [0:D-1];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_fill_verify_ctrl #(.WID_MEM(W), .DEPTH_MEM(D), .ERR_W(EW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .seed(seed),
        .abort(abort), .busy(busy), .done(done), .aborted(aborted),
        .err_cnt(err_cnt), .first_err_addr(first_err_addr),
        .usr_we(usr_we), .usr_waddr(usr_waddr), .usr_wdata(usr_wdata),
        .usr_re(usr_re), .usr_raddr(usr_raddr), .usr_gnt(usr_gnt),
        .usr_rdata(usr_rdata), .usr_rvalid(usr_rvalid),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_din(mem_din),
        .mem_raddr(mem_raddr), .mem_dout(mem_dout)
    );

    // Simple dual-port BRAM, 1-cycle read latency, read-first.
    always @(posedge clk) begin
        if (mem_we) mem_arr[mem_waddr[11:0]] <= mem_din;
        mem_dout <= mem_arr[mem_raddr[11:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] pat(input int a, input logic [W-1:0] s);
        logic [31:0] av;
        av = a;
        return av[W-1:0] ^ s;
    endfunction

    task automatic model_fill(input logic [W-1:0] s, input int upto);
        for (int a = 0; a < upto; a++) ref_mem[a] = pat(a, s);
    endtask

    task automatic model_verify(input logic [W-1:0] s, output int n, output int first);
        n = 0;
        first = 0;
        for (int a = 0; a < D; a++) begin
            if (ref_mem[a] != pat(a, s)) begin
                if (n == 0) first = a;
                n++;
            end
        end
        if (n > 65535) n = 65535;
    endtask

    task automatic begin_cmd(input logic [1:0] m, input logic [W-1:0] s);
        start = 1'b1;
        mode  = m;
        seed  = s;
        tick();
        start  = 1'b0;
        mode   = 2'b00;
        usr_we = 1'b0;
        usr_re = 1'b0;
    endtask

    // Runs from cycle 1 of a command until done; optional abort / user poke.
    task automatic wait_done(input string tag, input int abort_at, input int usr_at,
                             output int done_cyc, output int busy_cyc, output int we_cyc);
        int c;
        c = 1;
        busy_cyc = 0;
        we_cyc = 0;
        while (done !== 1'b1 && c < 3 * D) begin
            if (c == abort_at) begin
                abort = 1'b1;
                chk({tag, "_abort_raddr"}, mem_raddr, abort_at - 1);
            end
            if (c == usr_at) begin
                usr_we = 1'b1; usr_waddr = 32'd5; usr_wdata = 4'hF;
                usr_re = 1'b1; usr_raddr = 32'd5;
                #1;
                chk({tag, "_gnt_busy"}, usr_gnt, 0);
            end
            if (busy) busy_cyc++;
            if (mem_we) we_cyc++;
            tick();
            abort = 1'b0; usr_we = 1'b0; usr_re = 1'b0;
            c++;
        end
        done_cyc = c;
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy_at_done"}, busy, 0);
    endtask

    initial begin
        int dc, bc, wc, n, f, r;
        logic [W-1:0] s, s2, d;

        reset_n = 1'b0; start = 1'b0; mode = 2'b00; seed = 4'h0; abort = 1'b0;
        usr_we = 1'b0; usr_waddr = 32'd0; usr_wdata = 4'h0;
        usr_re = 1'b0; usr_raddr = 32'd0;
        for (int a = 0; a < D; a++) ref_mem[a] = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_aborted", aborted, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_first", first_err_addr, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_waddr", mem_waddr, 0);
        chk("rst_raddr", mem_raddr, 0);
        chk("rst_rvalid", usr_rvalid, 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        chk("idle_gnt", usr_gnt, 1);

        // mode 00 start and idle abort are ignored
        start = 1'b1; mode = 2'b00; tick(); start = 1'b0;
        chk("mode0_busy", busy, 0);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("idle_abort_busy", busy, 0);
        chk("idle_abort_done", done, 0);

        // 1: fill+verify seed A
        begin_cmd(2'b11, 4'hA);
        chk("t1_waddr0", mem_waddr, 0);
        chk("t1_we0", mem_we, 1);
        chk("t1_din0", mem_din, pat(0, 4'hA));
        wait_done("t1", -1, -1, dc, bc, wc);
        model_fill(4'hA, D);
        chk("t1_done_cyc", dc, 2 * D + 2);
        chk("t1_busy_cyc", bc, 2 * D + 1);
        chk("t1_we_cyc", wc, D);
        chk("t1_err", err_cnt, 0);
        chk("t1_aborted", aborted, 0);
        start = 1'b1; mode = 2'b01; tick(); start = 1'b0; mode = 2'b00;
        chk("t1_start_in_done", busy, 0);
        chk("t1_done_pulse", done, 0);
        chk("t1_waddr_hi", {20'd0, mem_waddr[31:12]}, 0);

        // 6: user write then read; same-cycle read/write returns old data
        usr_we = 1'b1; usr_waddr = 32'd7; usr_wdata = 4'h5;
        #1;
        chk("t6_gnt", usr_gnt, 1);
        chk("t6_mem_we", mem_we, 1);
        chk("t6_waddr", mem_waddr, 7);
        tick(); usr_we = 1'b0; ref_mem[7] = 4'h5;
        usr_re = 1'b1; usr_raddr = 32'd7;
        tick(); usr_re = 1'b0;
        chk("t6_rvalid", usr_rvalid, 1);
        chk("t6_rdata", usr_rdata, 4'h5);
        tick();
        chk("t6_rvalid_off", usr_rvalid, 0);
        usr_we = 1'b1; usr_waddr = 32'd7; usr_wdata = 4'hC; usr_re = 1'b1; usr_raddr = 32'd7;
        tick(); usr_we = 1'b0; usr_re = 1'b0; ref_mem[7] = 4'hC;
        chk("t6_rd_first", usr_rdata, 4'h5);
        chk("t6_raddr_hold", mem_raddr, 7);
        chk("t6_raddr_hi", {20'd0, mem_raddr[31:12]}, 0);
        usr_re = 1'b1; tick(); usr_re = 1'b0;
        chk("t6_rd_new", usr_rdata, 4'hC);

        // 2: fill seed 3, corrupt 0x123, verify seed 3
        begin_cmd(2'b01, 4'h3);
        wait_done("t2f", -1, -1, dc, bc, wc);
        model_fill(4'h3, D);
        chk("t2_fill_cyc", dc, D + 1);
        tick();
        usr_we = 1'b1; usr_waddr = 32'h123; usr_wdata = 4'h1;
        tick(); usr_we = 1'b0; ref_mem[32'h123] = 4'h1;
        begin_cmd(2'b10, 4'h3);
        wait_done("t2v", -1, -1, dc, bc, wc);
        model_verify(4'h3, n, f);
        chk("t2_verify_cyc", dc, D + 2);
        chk("t2_we_cyc", wc, 0);
        chk("t2_err", err_cnt, n);
        chk("t2_first", first_err_addr, f);
        tick();

        // 3: user write during fill is dropped
        s = 4'($urandom);
        begin_cmd(2'b01, s);
        wait_done("t3f", -1, 50, dc, bc, wc);
        model_fill(s, D);
        tick();
        begin_cmd(2'b10, s);
        wait_done("t3v", -1, -1, dc, bc, wc);
        chk("t3_err", err_cnt, 0);
        tick();

        // 4: abort verify at read address 100
        begin_cmd(2'b10, s);
        wait_done("t4", 101, -1, dc, bc, wc);
        chk("t4_done_cyc", dc, 102);
        chk("t4_aborted", aborted, 1);
        chk("t4_err", err_cnt, 0);
        tick();
        chk("t4_busy_after", busy, 0);
        chk("t4_aborted_hold", aborted, 1);

        // 5: async reset mid-fill
        begin_cmd(2'b01, 4'h5);
        repeat (2000) tick();
        chk("t5_waddr", mem_waddr, 2000);
        reset_n = 1'b0;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_mem_we", mem_we, 0);
        model_fill(4'h5, 2000);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        chk("t5_gnt", usr_gnt, 1);
        chk("t5_err", err_cnt, 0);
        chk("t5_busy_after", busy, 0);

        // random user traffic then random-seed verify
        for (int i = 0; i < 16; i++) begin
            r = int'($urandom_range(D - 1, 0));
            d = 4'($urandom);
            usr_we = 1'b1; usr_waddr = r; usr_wdata = d;
            tick(); usr_we = 1'b0; ref_mem[r] = d;
        end
        for (int i = 0; i < 16; i++) begin
            r = int'($urandom_range(D - 1, 0));
            usr_re = 1'b1; usr_raddr = r;
            tick(); usr_re = 1'b0;
            chk("rnd_rdata", usr_rdata, ref_mem[r]);
        end
        s2 = 4'($urandom);
        begin_cmd(2'b10, s2);
        wait_done("rndv", -1, -1, dc, bc, wc);
        model_verify(s2, n, f);
        chk("rnd_err", err_cnt, n);
        chk("rnd_first", first_err_addr, f);
        tick();

        // read accepted in the same cycle the command starts
        r = int'($urandom_range(D - 1, 0));
        s = 4'($urandom);
        usr_re = 1'b1; usr_raddr = r;
        begin_cmd(2'b11, s);
        chk("lv_rvalid", usr_rvalid, 1);
        chk("lv_rdata", usr_rdata, ref_mem[r]);
        chk("lv_busy", busy, 1);
        wait_done("lv", -1, -1, dc, bc, wc);
        model_fill(s, D);
        chk("lv_err", err_cnt, 0);
        chk("lv_done_cyc", dc, 2 * D + 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
